// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem requests for PC and loads the IF/ID register.
// Latency: fetched word appears in IF/ID on the same edge that PC advances (zero added).
// Backpressure: Stall parks an accepted word in a one-entry hold buffer; Flush bubbles IF/ID.
module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] PC,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        ImemReady,
   input  logic [31:0] ImemData,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   output logic        PCWrite,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid
);

   // FETCH: a request is outstanding for PC. HOLD: an accepted word waits in the buffer.
   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // What the IF/ID register does at the next edge.
   typedef enum logic [1:0] {
      IFID_KEEP   = 2'd0,
      IFID_MEM    = 2'd1,
      IFID_BUF    = 2'd2,
      IFID_BUBBLE = 2'd3
   } ifid_op_t;

   state_t      r_state;
   state_t      w_state_nxt;
   ifid_op_t    w_ifid_op;
   logic        w_buf_load;
   logic        w_buf_clr;
   logic        w_pcwrite;
   logic        w_imem_req;
   logic [31:0] w_pc_plus4;

   logic [31:0] r_buf_instr;
   logic [31:0] r_buf_pcplus4;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pcplus4;
   logic        r_ifid_valid;

   // PC+4 wraps modulo 2^32; no alignment check is made here.
   assign w_pc_plus4 = PC + 32'd4;

   // Address follows PC directly so the request is valid in the same cycle as PC.
   assign ImemAddr = PC;

   // Reset forces the handshake and PC-advance outputs low regardless of state.
   assign ImemReq = w_imem_req & ~Rst;
   assign PCWrite = w_pcwrite & ~Rst;

   assign IFID_Instr   = r_ifid_instr;
   assign IFID_PCPlus4 = r_ifid_pcplus4;
   assign IFID_Valid   = r_ifid_valid;

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, IF/ID action and PC-advance decode; Flush outranks Stall and ImemReady.
   always_comb begin
      w_state_nxt = r_state;
      w_ifid_op   = IFID_KEEP;
      w_buf_load  = 1'b0;
      w_buf_clr   = 1'b0;
      w_pcwrite   = 1'b0;
      w_imem_req  = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (Flush) begin
               // Branch path owns the PC this cycle; the in-flight word is dropped.
               w_ifid_op = IFID_BUBBLE;
            end else if (ImemReady && !Stall) begin
               w_ifid_op = IFID_MEM;
               w_pcwrite = 1'b1;
            end else if (ImemReady && Stall) begin
               // Memory already handed us the word; park it rather than re-fetch.
               w_buf_load  = 1'b1;
               w_state_nxt = ST_HOLD;
            end else if (!Stall) begin
               // Memory wait with decode free: feed a bubble, keep requesting same PC.
               w_ifid_op = IFID_BUBBLE;
            end
         end
         ST_HOLD: begin
            // No new request while the buffer is occupied.
            if (Flush) begin
               w_buf_clr   = 1'b1;
               w_ifid_op   = IFID_BUBBLE;
               w_state_nxt = ST_FETCH;
            end else if (!Stall) begin
               // PC advances now, so the next FETCH requests the following address.
               w_ifid_op   = IFID_BUF;
               w_pcwrite   = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         default: begin
            w_ifid_op   = IFID_BUBBLE;
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   // One-entry hold buffer for a word accepted while decode was stalled.
   always_ff @(posedge Clk) begin
      if (Rst || w_buf_clr) begin
         r_buf_instr   <= NOP_INSTR;
         r_buf_pcplus4 <= 32'd0;
      end else if (w_buf_load) begin
         r_buf_instr   <= ImemData;
         r_buf_pcplus4 <= w_pc_plus4;
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_ifid_instr   <= NOP_INSTR;
         r_ifid_pcplus4 <= 32'd0;
         r_ifid_valid   <= 1'b0;
      end else begin
         case (w_ifid_op)
            IFID_MEM: begin
               r_ifid_instr   <= ImemData;
               r_ifid_pcplus4 <= w_pc_plus4;
               r_ifid_valid   <= 1'b1;
            end
            IFID_BUF: begin
               r_ifid_instr   <= r_buf_instr;
               r_ifid_pcplus4 <= r_buf_pcplus4;
               r_ifid_valid   <= 1'b1;
            end
            IFID_BUBBLE: begin
               r_ifid_instr   <= NOP_INSTR;
               r_ifid_pcplus4 <= 32'd0;
               r_ifid_valid   <= 1'b0;
            end
            default: begin
               r_ifid_instr   <= r_ifid_instr;
               r_ifid_pcplus4 <= r_ifid_pcplus4;
               r_ifid_valid   <= r_ifid_valid;
            end
         endcase
      end
   end

endmodule
